// File: rtl/handshake_tx_ctrl.sv
// Send side of a 4-phase req/ack crossing with a one-word pending buffer.
// Optional sticky phase timeout is compiled in with HANDSHAKE_TX_TIMEOUT_EN.
module handshake_tx_ctrl #(
  parameter int DATA_WIDTH     = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_req,
  output logic [DATA_WIDTH-1:0] o_req_data,
  input  logic                  i_ack,
  output logic                  o_busy,
  output logic                  o_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] out_data, buf_data;
  logic                  buf_full, req, req_next;
  logic                  launch_buf, launch_in, accept, write_buf;

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("handshake_tx_ctrl: TIMEOUT_CYCLES must be >= 2");
  end

  assign accept     = i_valid && !buf_full;
  // A word taken in IDLE goes straight to out_data; everything else is parked
  assign write_buf  = accept && !launch_in;
  assign o_ready    = !buf_full;
  assign o_busy     = (state != IDLE) || buf_full;
  assign o_req      = req;
  assign o_req_data = out_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      req   <= 1'b0;
    end else begin
      state <= state_next;
      req   <= req_next;
    end
  end

  always_comb begin
    state_next = state;
    req_next   = req;
    launch_buf = 1'b0;
    launch_in  = 1'b0;
    case (state)
      IDLE: begin
        if (buf_full) begin
          launch_buf = 1'b1;
          req_next   = 1'b1;
          state_next = REQ;
        end else if (i_valid) begin
          launch_in  = 1'b1;
          req_next   = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (i_ack) begin
          req_next   = 1'b0;
          state_next = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!i_ack) begin
          if (buf_full) begin
            launch_buf = 1'b1;
            req_next   = 1'b1;
            state_next = REQ;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_data <= '0;
      buf_data <= '0;
      buf_full <= 1'b0;
    end else begin
      if (launch_buf)
        out_data <= buf_data;
      else if (launch_in)
        out_data <= i_data;

      if (launch_buf) begin
        buf_full <= 1'b0;
      end else if (write_buf) begin
        buf_full <= 1'b1;
        buf_data <= i_data;
      end
    end
  end

`ifdef HANDSHAKE_TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] phase_cnt;
  logic          timeout;
  logic          in_phase;

  assign in_phase  = (state != IDLE) && (state_next == state);
  assign o_timeout = timeout;

  // The flag sets on the same edge the counter reaches TIMEOUT_CYCLES
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      phase_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      if (state_next != state)
        phase_cnt <= '0;
      else if (in_phase && phase_cnt != CW'(TIMEOUT_CYCLES))
        phase_cnt <= phase_cnt + CW'(1);
      if (in_phase && phase_cnt == CW'(TIMEOUT_CYCLES - 1))
        timeout <= 1'b1;
    end
  end
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_handshake_tx_ctrl.sv
// Self-checking bench for handshake_tx_ctrl: directed vector table, corner
// sequences, and random traffic against a queue-level handshake model.
module tb_handshake_tx_ctrl;

  localparam int DW = 8;

  logic          clk, rst, valid, ready, ack, req, busy, timeout;
  logic [DW-1:0] data, req_data;

  int tests  = 0;
  int failed = 0;

  handshake_tx_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_data(data), .o_req(req), .o_req_data(req_data), .i_ack(ack),
    .o_busy(busy), .o_timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          a;
    logic          req;
    logic [DW-1:0] rd;
    logic          rdy;
    logic          bsy;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(logic v, logic [DW-1:0] d, logic a,
                              logic r, logic [DW-1:0] rd, logic rdy, logic b);
    vec_t x;
    x.v = v; x.d = d; x.a = a; x.req = r; x.rd = rd; x.rdy = rdy; x.bsy = b;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    valid = 1'b0; data = '0; ack = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference model: pending words as a queue, handshake as a phase
  // (0 = nothing in flight, 1 = waiting for ack high, 2 = waiting for ack low)
  int            m_phase;
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_cur;

  task automatic model_step(logic v, logic [DW-1:0] d, logic a);
    logic acc, bypass;
    acc    = v && (m_q.size() == 0);
    bypass = 1'b0;
    if (m_phase == 1) begin
      if (a) m_phase = 2;
    end else if (m_phase == 2) begin
      if (!a) begin
        if (m_q.size() != 0) begin
          m_cur = m_q.pop_front();
          m_phase = 1;
        end else begin
          m_phase = 0;
        end
      end
    end else begin
      if (m_q.size() != 0) begin
        m_cur = m_q.pop_front();
        m_phase = 1;
      end else if (acc) begin
        m_cur = d;
        m_phase = 1;
        bypass = 1'b1;
      end
    end
    if (acc && !bypass) m_q.push_back(d);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; data = '0; ack = 1'b0;

    vecs[0]  = mk(1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1);
    vecs[1]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1);
    vecs[2]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1);
    vecs[3]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    vecs[4]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    vecs[5]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0);
    vecs[6]  = mk(1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1);
    vecs[7]  = mk(1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
    vecs[8]  = mk(1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
    vecs[9]  = mk(1'b1, 8'h5A, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1);
    vecs[10] = mk(1'b1, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1);
    vecs[11] = mk(1'b1, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1);
    vecs[12] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0, 1'b1);
    vecs[13] = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b1, 1'b1);
    vecs[14] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 1'b1, 1'b1);
    vecs[15] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0);
    vecs[16] = mk(1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1);
    vecs[17] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1);
    vecs[18] = mk(1'b1, 8'h22, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1);
    vecs[19] = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1);
    vecs[20] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 1'b1, 1'b1);
    vecs[21] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0);
    vecs[22] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0);
    vecs[23] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0);
    vecs[24] = mk(1'b1, 8'h33, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1);
    vecs[25] = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1);
    vecs[26] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 1'b1, 1'b1);

    do_reset();
    chk("reset_req", {31'd0, req}, 32'd0);
    chk("reset_req_data", {24'd0, req_data}, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_timeout", {31'd0, timeout}, 32'd0);

    for (int i = 0; i < 27; i++) begin
      valid = vecs[i].v; data = vecs[i].d; ack = vecs[i].a;
      tick();
      chk($sformatf("vec%0d_req", i), {31'd0, req}, {31'd0, vecs[i].req});
      chk($sformatf("vec%0d_req_data", i), {24'd0, req_data}, {24'd0, vecs[i].rd});
      chk($sformatf("vec%0d_ready", i), {31'd0, ready}, {31'd0, vecs[i].rdy});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].bsy});
    end

    // ack stuck high in WAIT_LOW: nothing moves until it falls
    valid = 1'b0; ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_ack_req", {31'd0, req}, 32'd0);
      chk("hold_ack_busy", {31'd0, busy}, 32'd1);
    end
    ack = 1'b0;
    tick();
    chk("hold_ack_done_busy", {31'd0, busy}, 32'd0);
    chk("hold_ack_done_req", {31'd0, req}, 32'd0);

    // reset in REQ with a word buffered
    valid = 1'b1; data = 8'h3C; ack = 1'b0;
    tick();
    chk("rst_mid_launch", {31'd0, req}, 32'd1);
    data = 8'h4D;
    tick();
    chk("rst_mid_buffered", {31'd0, ready}, 32'd0);
    valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_req", {31'd0, req}, 32'd0);
    chk("rst_async_ready", {31'd0, ready}, 32'd1);
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_data", {24'd0, req_data}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ack = i[0];
      tick();
      chk("rst_no_replay_req", {31'd0, req}, 32'd0);
      chk("rst_no_replay_busy", {31'd0, busy}, 32'd0);
    end

    // phase timeout with ack stuck low
    do_reset();
    valid = 1'b1; data = 8'h77; ack = 1'b0;
    tick();
    valid = 1'b0;
    chk("to_launch_data", {24'd0, req_data}, 32'h77);
    for (int i = 0; i < 15; i++) tick();
    chk("to_before", {31'd0, timeout}, 32'd0);
    tick();
`ifdef HANDSHAKE_TX_TIMEOUT_EN
    chk("to_set", {31'd0, timeout}, 32'd1);
`else
    chk("to_disabled", {31'd0, timeout}, 32'd0);
`endif
    chk("to_still_req", {31'd0, req}, 32'd1);
    ack = 1'b1;
    tick();
    tick();
    ack = 1'b0;
    tick();
    chk("to_done_busy", {31'd0, busy}, 32'd0);
`ifdef HANDSHAKE_TX_TIMEOUT_EN
    chk("to_sticky", {31'd0, timeout}, 32'd1);
`else
    chk("to_sticky_disabled", {31'd0, timeout}, 32'd0);
`endif
    do_reset();
    chk("to_cleared", {31'd0, timeout}, 32'd0);

    // random traffic against the model
    m_phase = 0; m_q.delete(); m_cur = '0;
    for (int i = 0; i < 500; i++) begin
      valid = 1'($urandom_range(0, 1));
      data  = DW'($urandom);
      ack   = 1'($urandom_range(0, 1));
      model_step(valid, data, ack);
      tick();
      chk("rnd_req", {31'd0, req}, {31'd0, (m_phase == 1)});
      chk("rnd_req_data", {24'd0, req_data}, {24'd0, m_cur});
      chk("rnd_ready", {31'd0, ready}, {31'd0, (m_q.size() == 0)});
      chk("rnd_busy", {31'd0, busy}, {31'd0, (m_phase != 0 || m_q.size() != 0)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
